// File: rtl/mii_frame_streamer_pkg.sv
// Shared encodings for the MII frame streamer: FSM states, preamble/SFD nibbles, counter sizing.
package mii_frame_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA_LO,
        ST_DATA_HI,
        ST_IFG
    } state_t;

    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hD;
    localparam int         PRE_NIBBLES  = 16;

    // One counter serves both the preamble phase and the inter-frame gap.
    function automatic int cnt_width(input int ifg_nibbles);
        int span;
        span = (ifg_nibbles + 1 > PRE_NIBBLES) ? ifg_nibbles + 1 : PRE_NIBBLES;
        return $clog2(span);
    endfunction

endpackage

// File: rtl/mii_frame_streamer.sv
// Reads LEN bytes from the EBR at BASE and emits preamble+SFD, data nibbles (low first) and an IFG on tick.
// Frame takes 16*PREAMBLE_EN + 2*LEN + IFG_NIBBLES ticks; requests are accepted only in IDLE, never queued.
module mii_frame_streamer
    import mii_frame_streamer_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int LEN_W       = 5,
    parameter int IFG_NIBBLES = 24,
    parameter int PREAMBLE_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick,
    input  logic              i_start_valid,
    output logic              o_start_ready,
    input  logic [ADDR_W-1:0] i_start_base,
    input  logic [LEN_W-1:0]  i_start_len,
    output logic [ADDR_W-1:0] o_ram_addr,
    input  logic [7:0]        i_ram_rdata,
    output logic [3:0]        o_tx_d,
    output logic              o_tx_en,
    output logic              o_busy,
    output logic              o_done
);

    localparam int                CNT_W    = cnt_width(IFG_NIBBLES);
    localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(PRE_NIBBLES - 1);
    localparam logic [CNT_W-1:0]  IFG_LAST = CNT_W'(IFG_NIBBLES - 1);

    state_t            r_state,  w_state_nxt;
    logic [ADDR_W-1:0] r_addr,   w_addr_nxt;
    logic [LEN_W-1:0]  r_len,    w_len_nxt;
    logic [3:0]        r_hold,   w_hold_nxt;
    logic [3:0]        r_tx_d,   w_tx_d_nxt;
    logic              r_tx_en,  w_tx_en_nxt;
    logic              r_busy,   w_busy_nxt;
    logic              r_done,   w_done_nxt;
    logic              r_primed, w_primed_nxt;
    logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
    logic              w_accept;

    assign w_accept      = i_start_valid && (r_state == ST_IDLE);
    assign o_start_ready = (r_state == ST_IDLE);
    assign o_ram_addr    = r_addr;
    assign o_tx_d        = r_tx_d;
    assign o_tx_en       = r_tx_en;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_len    <= '0;
            r_hold   <= '0;
            r_tx_d   <= '0;
            r_tx_en  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_primed <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_len    <= w_len_nxt;
            r_hold   <= w_hold_nxt;
            r_tx_d   <= w_tx_d_nxt;
            r_tx_en  <= w_tx_en_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_primed <= w_primed_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_len_nxt    = r_len;
        w_hold_nxt   = r_hold;
        w_tx_d_nxt   = r_tx_d;
        w_tx_en_nxt  = r_tx_en;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_primed_nxt = 1'b1;
        w_cnt_nxt    = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_addr_nxt   = i_start_base;
                    w_len_nxt    = i_start_len;
                    w_cnt_nxt    = '0;
                    w_primed_nxt = 1'b0;
                    if (i_start_len == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = (PREAMBLE_EN != 0) ? ST_PRE : ST_DATA_LO;
                    end
                end
            end
            ST_PRE: begin
                if (i_tick) begin
                    w_tx_en_nxt = 1'b1;
                    w_tx_d_nxt  = (r_cnt == PRE_LAST) ? SFD_NIB : PREAMBLE_NIB;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    if (r_cnt == PRE_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DATA_LO;
                    end
                end
            end
            // r_primed holds off the first byte until the EBR output reflects the new base address.
            ST_DATA_LO: begin
                if (i_tick && r_primed) begin
                    w_tx_en_nxt = 1'b1;
                    w_tx_d_nxt  = i_ram_rdata[3:0];
                    w_hold_nxt  = i_ram_rdata[7:4];
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    w_state_nxt = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (i_tick) begin
                    w_tx_d_nxt  = r_hold;
                    w_len_nxt   = r_len - LEN_W'(1);
                    w_state_nxt = (r_len == LEN_W'(1)) ? ST_IFG : ST_DATA_LO;
                    w_cnt_nxt   = '0;
                end
            end
            ST_IFG: begin
                if (i_tick) begin
                    w_tx_en_nxt = 1'b0;
                    w_tx_d_nxt  = '0;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    if (r_cnt == IFG_LAST) begin
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
